// File: rtl/kernel_conv2d_acc_pkg.sv
// Shared widths and defaults for the conv2d accumulate kernel.
// Holds default sizes, derived-width helpers and the MAXPROD bound.
package kernel_conv2d_acc_pkg;

    localparam int BIT_DATA_DEF = 8;
    localparam int KSIZE_DEF    = 9;
    localparam int CIN_DEF      = 4;

    function automatic int f_bit1(int bd);
        return 2 * bd;
    endfunction

    function automatic int f_bit2(int bd, int ks);
        return f_bit1(bd) + $clog2(ks);
    endfunction

    function automatic int f_bitacc(int bd, int ks, int cin);
        return f_bit2(bd, ks) + $clog2(cin) + 1;
    endfunction

    function automatic int f_tlev(int ks);
        return $clog2(ks);
    endfunction

    // Largest single product magnitude: (-2^(bd-1))^2.
    function automatic longint f_maxprod(int bd);
        return longint'(1) << (2 * bd - 2);
    endfunction

    localparam longint MAXPROD = f_maxprod(BIT_DATA_DEF);

endpackage

// File: rtl/kernel_conv2d_acc_adder_tree_pipe.sv
// Registered binary adder tree with enable and sideband pass-through.
// Ports: clk, reset_n (sync, low), en, in_valid/in_sb/in_data (N x W
// signed), out_valid/out_sb/out_sum (OW signed); clog2(N) levels.
module kernel_conv2d_acc_adder_tree_pipe #(
    parameter int N   = 9,
    parameter int W   = 16,
    parameter int OW  = 20,
    parameter int SBW = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           in_valid,
    input  logic [SBW-1:0] in_sb,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    output logic [SBW-1:0] out_sb,
    output logic [OW-1:0]  out_sum
);

    localparam int T = $clog2(N);

    function automatic int f_cnt(int l);
        return (N + (1 << l) - 1) >> l;
    endfunction

    logic [N*OW-1:0] w_ext;

    always_comb begin
        w_ext = '0;
        for (int i = 0; i < N; i++) begin
            w_ext[i*OW +: OW] = {{(OW-W){in_data[i*W+W-1]}},
                                 in_data[i*W +: W]};
        end
    end

    for (genvar l = 1; l <= T; l++) begin : g_lvl
        localparam int NC = f_cnt(l);

        // Previous level zero-padded to an even count, so an odd
        // operand simply adds zero and passes through.
        logic [2*NC*OW-1:0] w_p;
        logic               w_pv;
        logic [SBW-1:0]     w_psb;
        logic [NC*OW-1:0]   r_v;
        logic               r_valid;
        logic [SBW-1:0]     r_sb;

        if (l == 1) begin : g_src
            assign w_p   = (2*NC*OW)'(w_ext);
            assign w_pv  = in_valid;
            assign w_psb = in_sb;
        end else begin : g_src
            assign w_p   = (2*NC*OW)'(g_lvl[l-1].r_v);
            assign w_pv  = g_lvl[l-1].r_valid;
            assign w_psb = g_lvl[l-1].r_sb;
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
            end else if (en) begin
                r_valid <= w_pv;
            end
            if (en) begin
                r_sb <= w_psb;
                for (int j = 0; j < NC; j++) begin
                    r_v[j*OW +: OW] <= w_p[2*j*OW +: OW]
                                     + w_p[(2*j+1)*OW +: OW];
                end
            end
        end
    end

    assign out_valid = g_lvl[T].r_valid;
    assign out_sb    = g_lvl[T].r_sb;
    assign out_sum   = g_lvl[T].r_v;

endmodule

// File: rtl/kernel_conv2d_acc.sv
// Conv2d kernel: KSIZE parallel MACs, adder tree, CIN-beat accumulate,
// bias and ReLU. Ports: clk, reset_n (sync, low); in_valid/in_ready,
// in_x/in_w (KSIZE packed signed taps), in_bias (beat 0 only);
// out_valid/out_ready, out_y (>=0), out_et (early-termination flag).
// Optional: define KERNEL_EARLY_TERM_EN to enable early termination.
module kernel_conv2d_acc
    import kernel_conv2d_acc_pkg::*;
#(
    parameter  int BIT_DATA = BIT_DATA_DEF,
    parameter  int KSIZE    = KSIZE_DEF,
    parameter  int CIN      = CIN_DEF,
    localparam int BITACC   = f_bitacc(BIT_DATA, KSIZE, CIN)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIT_DATA*KSIZE-1:0] in_x,
    input  logic [BIT_DATA*KSIZE-1:0] in_w,
    input  logic [BITACC-1:0]         in_bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BITACC-1:0]         out_y,
    output logic                      out_et
);

    localparam int BIT1 = f_bit1(BIT_DATA);
    localparam int BIT2 = f_bit2(BIT_DATA, KSIZE);
    localparam int KW   = (CIN > 1) ? $clog2(CIN) : 1;
    localparam int SBW  = KW + 2 + BITACC;
    localparam int BD   = BIT_DATA;

    logic              w_en;
    logic              r_out_valid;
    logic [BITACC-1:0] r_out_y;

    // One global stall: everything moves only when the output can take
    // a new result.
    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;

    logic [KW-1:0] r_cnt;
    logic          w_first;
    logic          w_last;

    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == KW'(CIN - 1));

    logic [KSIZE*BIT1-1:0] w_prod;

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < KSIZE; i++) begin
            w_prod[i*BIT1 +: BIT1] =
                $signed({{BD{in_x[i*BD+BD-1]}}, in_x[i*BD +: BD]})
              * $signed({{BD{in_w[i*BD+BD-1]}}, in_w[i*BD +: BD]});
        end
    end

    logic                  r_p_valid;
    logic [SBW-1:0]        r_p_sb;
    logic [KSIZE*BIT1-1:0] r_prod;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_p_valid <= 1'b0;
        end else if (w_en) begin
            r_p_valid <= in_valid;
            if (in_valid) begin
                r_cnt <= w_last ? '0 : r_cnt + KW'(1);
            end
        end
        if (w_en && in_valid) begin
            r_prod <= w_prod;
            r_p_sb <= {r_cnt, w_last, w_first,
                       w_first ? in_bias : '0};
        end
    end

    logic            w_t_valid;
    logic [SBW-1:0]  w_t_sb;
    logic [BIT2-1:0] w_t_sum;

    kernel_conv2d_acc_adder_tree_pipe #(
        .N   (KSIZE),
        .W   (BIT1),
        .OW  (BIT2),
        .SBW (SBW)
    ) u_tree (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (w_en),
        .in_valid  (r_p_valid),
        .in_sb     (r_p_sb),
        .in_data   (r_prod),
        .out_valid (w_t_valid),
        .out_sb    (w_t_sb),
        .out_sum   (w_t_sum)
    );

    logic [KW-1:0]            w_t_k;
    logic                     w_t_last;
    logic                     w_t_first;
    logic [BITACC-1:0]        w_t_bias;
    logic signed [BITACC-1:0] w_sum;
    logic signed [BITACC-1:0] w_acc_nxt;
    logic signed [BITACC-1:0] r_acc;
    logic                     r_a_emit;

    assign w_t_k     = w_t_sb[SBW-1 -: KW];
    assign w_t_last  = w_t_sb[BITACC+1];
    assign w_t_first = w_t_sb[BITACC];
    assign w_t_bias  = w_t_sb[BITACC-1:0];
    assign w_sum     = {{(BITACC-BIT2){w_t_sum[BIT2-1]}}, w_t_sum};
    assign w_acc_nxt = (w_t_first ? w_t_bias : r_acc) + w_sum;

`ifdef KERNEL_EARLY_TERM_EN
    logic signed [BITACC:0] w_bound;
    logic [BITACC:0]        w_chk;
    logic                   w_et_hit;
    logic                   r_drop;
    logic                   r_a_et;
    logic                   r_out_et;

    // Even if every remaining beat delivered the maximum product on
    // every tap, acc + bound < 0 means ReLU will clamp to zero.
    always_comb begin
        w_bound  = (BITACC+1)'((longint'(CIN - 1) - longint'(w_t_k))
                 * longint'(KSIZE) * f_maxprod(BIT_DATA));
        w_chk    = {w_acc_nxt[BITACC-1], w_acc_nxt} + w_bound;
        w_et_hit = !w_t_last && w_chk[BITACC];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_a_emit <= 1'b0;
            r_a_et   <= 1'b0;
            r_drop   <= 1'b0;
        end else if (w_en) begin
            r_a_emit <= 1'b0;
            r_a_et   <= 1'b0;
            if (w_t_valid) begin
                if (r_drop) begin
                    if (w_t_last) r_drop <= 1'b0;
                end else begin
                    r_acc    <= w_acc_nxt;
                    r_a_emit <= w_t_last || w_et_hit;
                    r_a_et   <= w_et_hit;
                    r_drop   <= w_et_hit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_et <= 1'b0;
        end else if (w_en && r_a_emit) begin
            r_out_et <= r_a_et;
        end
    end

    assign out_et = r_out_et;
`else
    logic w_unused_k;

    assign w_unused_k = ^w_t_k;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_a_emit <= 1'b0;
        end else if (w_en) begin
            r_a_emit <= 1'b0;
            if (w_t_valid) begin
                r_acc    <= w_acc_nxt;
                r_a_emit <= w_t_last;
            end
        end
    end

    assign out_et = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
        end else if (w_en) begin
            r_out_valid <= r_a_emit;
            if (r_a_emit) begin
                r_out_y <= r_acc[BITACC-1] ? '0 : r_acc;
            end
        end
    end

endmodule

// File: tb/tb_kernel_conv2d_acc.sv
// Randomized bench for kernel_conv2d_acc against a window-level model.
// Covers reset, latency, extremes, ReLU, stall, early-term, mid reset.
module tb_kernel_conv2d_acc;

    localparam int BD   = 8;
    localparam int KS   = 9;
    localparam int CI   = 4;
    localparam int BA   = 2*BD + $clog2(KS) + $clog2(CI) + 1;
    localparam int LAT  = $clog2(KS) + 2;
    localparam longint PMAX = 16384;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BD*KS-1:0] in_x = '0;
    logic [BD*KS-1:0] in_w = '0;
    logic [BA-1:0] in_bias = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BA-1:0] out_y;
    logic          out_et;

    kernel_conv2d_acc #(
        .BIT_DATA (BD),
        .KSIZE    (KS),
        .CIN      (CI)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_et    (out_et)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    longint lat_edge = 0;
    bit     lat_chk = 1'b0;
    bit     acc_flag = 1'b0;
    int     rdy_pct = 100;

    longint mdl_acc = 0;
    int     mdl_k = 0;
    bit     mdl_drop = 1'b0;
    longint exp_y[$];
    bit     exp_et[$];

    task automatic check(string tag, logic signed [63:0] got,
                         logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_beat();
        longint s = 0;
        for (int i = 0; i < KS; i++) begin
            s += longint'($signed(in_x[i*BD +: BD]))
               * longint'($signed(in_w[i*BD +: BD]));
        end
        if (mdl_drop) begin
            if (mdl_k == CI-1) mdl_drop = 1'b0;
        end else begin
            if (mdl_k == 0) mdl_acc = longint'($signed(in_bias)) + s;
            else mdl_acc = mdl_acc + s;
            if (mdl_k == CI-1) begin
                exp_y.push_back(mdl_acc < 0 ? 0 : mdl_acc);
                exp_et.push_back(1'b0);
                lat_edge = cyc + 1;
            end
`ifdef KERNEL_EARLY_TERM_EN
            else if (mdl_acc + longint'(CI-1-mdl_k) * KS * PMAX < 0) begin
                exp_y.push_back(0);
                exp_et.push_back(1'b1);
                mdl_drop = 1'b1;
            end
`endif
        end
        mdl_k = (mdl_k == CI-1) ? 0 : mdl_k + 1;
    endtask

    task automatic step();
        out_ready = ($urandom_range(1, 100) <= rdy_pct);
        #1;
        check("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
            if (exp_y.size() == 0) begin
                check("out_unexpected", out_valid, 0);
            end else begin
                check("out_y", $signed(out_y), exp_y.pop_front());
                check("out_et", out_et, exp_et.pop_front());
                if (lat_chk) begin
                    check("latency", cyc - lat_edge, LAT);
                    lat_chk = 1'b0;
                end
            end
        end
        acc_flag = in_valid && in_ready;
        if (acc_flag) model_beat();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic fill(int mode);
        int xv;
        int wv;
        for (int i = 0; i < KS; i++) begin
            xv = $urandom_range(0, 255) - 128;
            wv = $urandom_range(0, 255) - 128;
            case (mode)
                1: begin xv = 1;    wv = 1;    end
                2: begin xv = -128; wv = -128; end
                3: begin xv = 1;    wv = -1;   end
                4: if (mdl_k == 0) begin xv = 0; wv = 0; end
                default: ;
            endcase
            in_x[i*BD +: BD] = BD'(xv);
            in_w[i*BD +: BD] = BD'(wv);
        end
    endtask

    task automatic send_beats(int nb, int mode, longint bias, int vpct);
        for (int b = 0; b < nb; b++) begin
            int guard;
            in_valid = 1'b0;
            while ($urandom_range(1, 100) > vpct) step();
            fill(mode);
            in_bias = (mdl_k == 0) ? BA'(bias) : BA'($urandom);
            in_valid = 1'b1;
            guard = 0;
            acc_flag = 1'b0;
            while (!acc_flag && guard < 500) begin
                step();
                guard++;
            end
            if (!acc_flag) check("accept_timeout", acc_flag, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        in_valid = 1'b0;
        while (exp_y.size() > 0 && guard < 300) begin
            step();
            guard++;
        end
        if (exp_y.size() > 0) check("drain_timeout", exp_y.size(), 0);
        repeat (8) step();
    endtask

    task automatic do_reset(int n);
        in_valid = 1'b0;
        reset_n = 1'b0;
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset_n = 1'b1;
        mdl_k = 0;
        mdl_drop = 1'b0;
        exp_y.delete();
        exp_et.delete();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", $signed(out_y), 0);
        check("rst_out_et", out_et, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    function automatic longint rbias();
        return longint'($urandom_range(0, 1200000)) - 600000;
    endfunction

    initial begin
        do_reset(3);

        lat_chk = 1'b1;
        send_beats(4, 1, 0, 100);
        drain();
        check("latency_seen", lat_chk, 0);

        send_beats(4, 2, -1, 100);
        drain();
        send_beats(4, 3, 5, 100);
        drain();

        rdy_pct = 0;
        send_beats(8, 0, rbias(), 100);
        repeat (10) step();
        check("stall_full", out_valid, 1);
        check("stall_queue", exp_y.size(), 2);
        rdy_pct = 100;
        drain();

        send_beats(4, 4, -2000000, 100);
        send_beats(4, 0, rbias(), 100);
        drain();

        send_beats(2, 0, rbias(), 100);
        do_reset(1);
        send_beats(4, 0, rbias(), 100);
        drain();

        rdy_pct = 70;
        for (int n = 0; n < 40; n++) begin
            send_beats(CI, 0, rbias(), 75);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_conv2d_acc.md
# kernel_conv2d_acc

Clocked, parametrised successor of the conv2d kernel datapath. Each input beat carries one KSIZE-tap window slice. The block multiplies the taps in parallel, reduces them through a registered adder tree, and accumulates CIN beats plus a bias into one ReLU-activated output. It sits between the window/weight fetch stage and the activation writer, with valid/ready handshakes on both sides. Optional early termination emits a known-zero result before all channels arrive.

## Interface
- BIT_DATA, 8, signed activation/weight width
- KSIZE, 9, taps per beat (≥2)
- CIN, 4, beats (input channels) per output (≥1)
- Derived: BIT1 = 2·BIT_DATA; BIT2 = BIT1 + clog2(KSIZE); BITACC = BIT2 + clog2(CIN) + 1; T = clog2(KSIZE) tree levels
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  reset, synchronous, active-low
- in_valid  in  1  beat available
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_x  in  BIT_DATA·KSIZE  signed activations, tap i at [BIT_DATA·(i+1)-1 : BIT_DATA·i]
- in_w  in  BIT_DATA·KSIZE  signed weights, same packing
- in_bias  in  BITACC  signed bias, sampled on beat 0 of each window only
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_y  out  BITACC  signed result, always ≥0 (ReLU)
- out_et  out  1  result produced by early termination; constant 0 when feature compiled out

## Operation
- Pipeline: product stage (KSIZE registered BIT1 products), T registered adder-tree levels (odd operand passes through, sign-extended to BIT2), then accumulator stage.
- Each stage carries valid, first (beat index 0), last (index CIN-1), beat index k, and bias (first beat only).
- Input beat counter: 0..CIN-1, increments on each accepted beat, wraps to 0 after CIN-1.
- Accumulator: on first, acc = bias + sum; otherwise acc = acc + sum. Full width, so no saturation is needed.
- On last, out_y = (acc < 0) ? 0 : acc, out_out_et = 0, and out_valid is set.
- Global stall: en = !out_valid || out_ready; in_ready = en. All stages advance only when en is high, so no beat is lost or duplicated.
- Output handshake and a new result in the same cycle: the new result replaces the old one and out_valid stays 1.

## Timing
- Reset (reset_n = 0 at an edge): all stage valids, counters, acc, out_y, out_valid and out_et go to 0. Any partial window is discarded. in_ready is 1 in the first cycle after reset.
- Latency: the last beat accepted at edge n produces out_valid at edge n+T+2 when there is no stall (6 for KSIZE=9).
- Throughput: one beat per cycle, so one output per CIN cycles.
- A stall freezes every register. Inputs need not be held when in_ready = 0, except that in_valid and its data persist until accepted.
- CIN = 1: every beat is both first and last.

## Configuration
- KERNEL_EARLY_TERM_EN defined:
  - After accumulating beat k < CIN-1, compute bound = (CIN-1-k)·KSIZE·2^(2·BIT_DATA-2).
  - If acc + bound < 0 (evaluated at BITACC+1 bits), emit out_y = 0 and out_et = 1 that cycle.
  - The accumulator then drops the remaining beats of that window (up to and including last) without output.
  - Input-side acceptance is unchanged.
- Undefined: no bound logic, no drop state, and out_et is tied to 0.

## Structure
- Shared package or definitions file holds BIT_DATA, KSIZE and CIN defaults, the derived width functions (BIT1, BIT2, BITACC, T), and the MAXPROD constant 2^(2·BIT_DATA-2).
- One natural sub-module: adder_tree_pipe (parametrised N inputs and width, registered levels, enable, sideband pass-through).

## Test plan
- All taps x=1, w=1, bias=0, 4 beats back-to-back -> out_y=36, out_et=0, out_valid exactly T+2=6 edges after the last beat.
- All taps x=-128, w=-128, bias=-1, 4 beats -> out_y=589823 (no overflow in 23 bits).
- All taps x=1, w=-1, bias=5 -> acc=-31, out_y=0, out_et=0.
- out_ready=0 for 10 cycles spanning two windows -> in_ready=0 while the output is full; both results are delivered in order, and no beat is lost or duplicated.
- KERNEL_EARLY_TERM_EN, bias=-2000000, beat 0 all zero -> out_y=0, out_et=1 at T+2 edges after beat 0; beats 1–3 are dropped; the following window gives its normal value.
- reset_n=0 for one edge after 2 beats of a window -> all outputs 0; the next 4 beats form a fresh window with the correct result.
